gpu_mem_arbiter: RTL and testbench
==================================

Name: gpu_mem_arbiter

Overview:
Round-robin arbiter that shares the Mini-GPU's single simplified memory-request channel between NUM_REQ requesters. The requesters are vector ALU load/store ports and scheduler fetch ports. The block sits between those requesters and the AXI master bridge and keeps exactly one transaction in flight. It latches the winning request, drives it downstream, captures the response, and returns the response only to the requester that issued it.

Parameters:
NUM_REQ, 4, number of requesters (>= 2)
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_is_write  in  NUM_REQ  per-requester write flag
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes
req_ready  out  NUM_REQ  one-hot accept pulse
resp_valid  out  NUM_REQ  one-hot response valid
resp_rdata  out  DATA_WIDTH  response data, shared by all requesters; meaningful only alongside resp_valid
resp_ready  in  NUM_REQ  per-requester response accept
m_req_valid  out  1  downstream request valid
m_req_is_write  out  1  downstream write flag
m_req_addr  out  ADDR_WIDTH  downstream address
m_req_wdata  out  DATA_WIDTH  downstream write data
m_req_wstrb  out  DATA_WIDTH/8  downstream strobes
m_req_ready  in  1  downstream accept
m_resp_rdata  in  DATA_WIDTH  downstream read data; value is don't-care on writes
m_resp_valid  in  1  downstream completion, asserted for both reads and writes
m_resp_ready  out  1  accept downstream completion
busy  out  1  high whenever state != IDLE
cur_grant  out  $clog2(NUM_REQ)  index of the latched grant; 0 in IDLE

Behaviour:
- Reset (async assert, sync deassert handled by the top level) drives:
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_ready, resp_valid, resp_rdata, all m_req_*, m_resp_ready, busy, cur_grant.
- FSM states are IDLE, ISSUE, WAIT_RESP and RETURN.
- IDLE:
  - If any req_valid is high, select the first set bit searching upward from rr_ptr with wrap-around.
  - Assert req_ready[g] combinationally in that cycle (one-hot, single-cycle pulse).
  - Latch g, is_write, addr, wdata and wstrb into holding registers, then go to ISSUE.
  - If no req_valid is high, stay in IDLE with no outputs asserted.
- ISSUE:
  - m_req_* driven from the holding registers; m_req_valid=1.
  - Fields stay stable until m_req_ready; on m_req_valid && m_req_ready, go to WAIT_RESP.
- WAIT_RESP:
  - m_resp_ready=1; m_req_valid=0.
  - On m_resp_valid, register m_resp_rdata into resp_rdata and go to RETURN.
  - Write completions are handled identically; resp_rdata takes the don't-care value.
- RETURN:
  - resp_valid[g]=1 until resp_ready[g].
  - On the handshake: rr_ptr <= (g+1) mod NUM_REQ, then go to IDLE.
- Outside WAIT_RESP, m_resp_ready=0. A stray m_resp_valid is not accepted and causes no state change.
- Minimum latency:
  - Accept in cycle 0.
  - m_req_valid in cycle 1.
  - With zero-wait downstream, m_resp_valid in cycle 2 and resp_valid in cycle 3.
  - Back in IDLE in cycle 4, assuming resp_ready is already high.
- Fairness: a continuously asserting requester is granted within NUM_REQ-1 completed transactions of other requesters.
- Requester rules: keep req_valid high and fields stable until req_ready. Deasserting req_valid before grant is legal and simply withdraws the request.
- Simultaneous events:
  - The requester granted in RETURN may re-request in the same cycle.
  - That request is evaluated in the following IDLE cycle against the updated rr_ptr.
- rr_ptr is $clog2(NUM_REQ) bits wide and wraps explicitly, so non-power-of-two NUM_REQ is supported.
- Reset in any state:
  - Abandons the in-flight transaction immediately.
  - No response is delivered to any requester.
  - The bridge is reset by the same rst_n.

Test Plan:
- Single read: req_valid[1]=1, addr=0x100; downstream returns 0xDEADBEEF after 3 cycles -> req_ready[1] pulses once; m_req_addr=0x100 with is_write=0; resp_valid[1] with resp_rdata=0xDEADBEEF; cur_grant=1 throughout.
- Simultaneous requests: req_valid=4'b0101 after reset -> grant order 0 then 2; rr_ptr=3 after the second completion.
- Fairness: all four requesters held high for 8 transactions -> grant sequence 0,1,2,3,0,1,2,3; busy is low for exactly 1 cycle between transactions.
- Backpressure: m_req_ready low for 5 cycles, then write addr=0x40, wdata=0x12345678, wstrb=4'b0011 -> m_req_* stable during the stall; a single handshake; resp_valid only after m_resp_valid.
- Response stall and stray response: resp_ready[3] held low 4 cycles, plus m_resp_valid pulsed while in ISSUE -> resp_valid[3] and resp_rdata held for 4 cycles; stray pulse ignored (m_resp_ready=0); no new req_ready during the stall.
- Reset in WAIT_RESP: rst_n asserted low mid-transaction -> all outputs 0 immediately; after release, a req_valid[2] request is granted first (rr_ptr=0 search order) and completes normally.

Source files
------------

// File: rtl/gpu_mem_arbiter_if.sv
// Memory-request bundle between NUM_REQ requesters, the arbiter and the downstream
// AXI master bridge.
//   slave  : arbiter view. It takes requests and m_* completions in, and drives
//            grants, responses and the downstream request out.
//   master : environment view (requesters plus bridge), the mirror of slave.
interface gpu_mem_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned PtrWidth  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_is_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*StrbWidth-1:0]  req_wstrb;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_rdata;
  logic [NUM_REQ-1:0]            resp_ready;

  logic                          m_req_valid;
  logic                          m_req_is_write;
  logic [ADDR_WIDTH-1:0]         m_req_addr;
  logic [DATA_WIDTH-1:0]         m_req_wdata;
  logic [StrbWidth-1:0]          m_req_wstrb;
  logic                          m_req_ready;
  logic [DATA_WIDTH-1:0]         m_resp_rdata;
  logic                          m_resp_valid;
  logic                          m_resp_ready;

  logic                          busy;
  logic [PtrWidth-1:0]           cur_grant;

  modport slave (
    input  req_valid, req_is_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  m_req_ready, m_resp_rdata, m_resp_valid,
    output req_ready, resp_valid, resp_rdata,
    output m_req_valid, m_req_is_write, m_req_addr, m_req_wdata, m_req_wstrb, m_resp_ready,
    output busy, cur_grant
  );

  modport master (
    output req_valid, req_is_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output m_req_ready, m_resp_rdata, m_resp_valid,
    input  req_ready, resp_valid, resp_rdata,
    input  m_req_valid, m_req_is_write, m_req_addr, m_req_wdata, m_req_wstrb, m_resp_ready,
    input  busy, cur_grant
  );
endinterface

// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory-request channel between NUM_REQ requesters.
// It keeps a single transaction in flight: it latches the winner, issues the request
// downstream, captures the completion and hands it back to the requester that issued it.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus_io - request, response, downstream and status signals (slave view)
module gpu_mem_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  gpu_mem_arbiter_if.slave bus_io
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned PtrWidth  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PtrWidth-1:0] LastIdx = PtrWidth'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StReturn} state_e;

  state_e                state_q, state_d;
  logic [PtrWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrWidth-1:0]   grant_q, grant_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  logic                pick_found;
  logic [PtrWidth-1:0] pick_idx;
  logic [PtrWidth-1:0] cand_idx;
  int unsigned         cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = PtrWidth'(cand);
      if (!pick_found && bus_io.req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (pick_found) state_d = StIssue;
      StIssue:    if (bus_io.m_req_ready) state_d = StWaitResp;
      StWaitResp: if (bus_io.m_resp_valid) state_d = StReturn;
      StReturn:   if (bus_io.resp_ready[grant_q]) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Holding registers, pointer and captured response.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    if (state_q == StIdle && pick_found) begin
      grant_d    = pick_idx;
      is_write_d = bus_io.req_is_write[pick_idx];
      addr_d     = bus_io.req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d    = bus_io.req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
      wstrb_d    = bus_io.req_wstrb[pick_idx*StrbWidth +: StrbWidth];
    end
    if (state_q == StWaitResp && bus_io.m_resp_valid) begin
      rdata_d = bus_io.m_resp_rdata;
    end
    if (state_q == StReturn && bus_io.resp_ready[grant_q]) begin
      // Explicit wrap keeps non-power-of-two NUM_REQ correct.
      rr_ptr_d = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
    end
  end

  // Outputs.
  logic [NUM_REQ-1:0] req_ready, resp_valid;
  logic               m_req_valid, m_req_is_write, m_resp_ready;
  logic [ADDR_WIDTH-1:0] m_req_addr;
  logic [DATA_WIDTH-1:0] m_req_wdata;
  logic [StrbWidth-1:0]  m_req_wstrb;

  always_comb begin
    req_ready      = '0;
    resp_valid     = '0;
    m_req_valid    = 1'b0;
    m_req_is_write = 1'b0;
    m_req_addr     = '0;
    m_req_wdata    = '0;
    m_req_wstrb    = '0;
    m_resp_ready   = 1'b0;
    case (state_q)
      StIdle: begin
        // Grant pulse is combinational from req_valid, so mask it while in reset.
        if (rst_n && pick_found) req_ready[pick_idx] = 1'b1;
      end
      StIssue: begin
        m_req_valid    = 1'b1;
        m_req_is_write = is_write_q;
        m_req_addr     = addr_q;
        m_req_wdata    = wdata_q;
        m_req_wstrb    = wstrb_q;
      end
      StWaitResp: m_resp_ready = 1'b1;
      StReturn:   resp_valid[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.req_ready      = req_ready;
  assign bus_io.resp_valid     = resp_valid;
  assign bus_io.resp_rdata     = rdata_q;
  assign bus_io.m_req_valid    = m_req_valid;
  assign bus_io.m_req_is_write = m_req_is_write;
  assign bus_io.m_req_addr     = m_req_addr;
  assign bus_io.m_req_wdata    = m_req_wdata;
  assign bus_io.m_req_wstrb    = m_req_wstrb;
  assign bus_io.m_resp_ready   = m_resp_ready;
  assign bus_io.busy           = (state_q != StIdle);
  assign bus_io.cur_grant      = (state_q == StIdle) ? '0 : grant_q;
endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed self-checking bench for gpu_mem_arbiter (NUM_REQ=4, 32-bit address and data).
// Inputs change 1 time unit after a rising edge, and outputs are sampled 1 unit later.
module tb_gpu_mem_arbiter;
  localparam int unsigned NumReq = 4;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;

  logic clk;
  logic rst_n;
  int unsigned errors = 0;
  int unsigned checks = 0;

  gpu_mem_arbiter_if #(.NUM_REQ(NumReq), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  gpu_mem_arbiter #(.NUM_REQ(NumReq), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid    = '0;
    bus.req_is_write = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_wstrb    = '0;
    bus.resp_ready   = '0;
    bus.m_req_ready  = 1'b0;
    bus.m_resp_valid = 1'b0;
    bus.m_resp_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int idx, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    bus.req_is_write[idx]    = w;
    bus.req_addr[idx*AW +: AW] = a;
    bus.req_wdata[idx*DW +: DW] = d;
    bus.req_wstrb[idx*4 +: 4]  = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear_inputs();
    #1;
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++;
      $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    checks++; if (bus.resp_valid !== 4'b0000) begin errors++;
      $display("FAIL reset_resp_valid: got %b want 0000", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
    checks++; if ({bus.m_req_valid, bus.m_req_is_write, bus.m_req_addr, bus.m_req_wdata,
                   bus.m_req_wstrb} !== '0) begin errors++;
      $display("FAIL reset_m_req: got v=%b a=%h want all zero", bus.m_req_valid,
               bus.m_req_addr); end
    checks++; if ({bus.m_resp_ready, bus.busy} !== 2'b00) begin errors++;
      $display("FAIL reset_ready_busy: got %b%b want 00", bus.m_resp_ready, bus.busy); end
    checks++; if (bus.cur_grant !== 2'd0) begin errors++;
      $display("FAIL reset_cur_grant: got %0d want 0", bus.cur_grant); end
    tick();
    checks++; if ({bus.busy, bus.req_ready} !== 5'b0) begin errors++;
      $display("FAIL reset_held: got busy=%b req_ready=%b want 0/0000", bus.busy,
               bus.req_ready); end
    bus.req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    bus.m_req_ready = 1'b1;
    set_req(1, 1'b0, 32'h100, 32'h0, 4'h0);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++;
      $display("FAIL single_req_ready: got %b want 0010", bus.req_ready); end
    checks++; if (bus.cur_grant !== 2'd0) begin errors++;
      $display("FAIL single_grant_idle: got %0d want 0", bus.cur_grant); end
    tick();
    bus.req_valid = '0;
    #1;
    checks++; if ({bus.m_req_valid, bus.m_req_is_write, bus.m_req_addr} !== {2'b10, 32'h100})
      begin errors++;
      $display("FAIL single_issue: got v=%b w=%b a=%h want v=1 w=0 a=100", bus.m_req_valid,
               bus.m_req_is_write, bus.m_req_addr); end
    checks++; if ({bus.cur_grant, bus.req_ready} !== {2'd1, 4'b0000}) begin errors++;
      $display("FAIL single_issue_grant: got g=%0d rr=%b want 1/0000", bus.cur_grant,
               bus.req_ready); end
    tick();
    #1;
    checks++; if ({bus.m_req_valid, bus.m_resp_ready} !== 2'b01) begin errors++;
      $display("FAIL single_wait: got mv=%b mr=%b want 0/1", bus.m_req_valid,
               bus.m_resp_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++; if ({bus.resp_valid, bus.cur_grant} !== {4'b0000, 2'd1}) begin errors++;
        $display("FAIL single_wait_hold: got rv=%b g=%0d want 0000/1", bus.resp_valid,
                 bus.cur_grant); end
    end
    bus.m_resp_valid = 1'b1;
    bus.m_resp_rdata = 32'hDEAD_BEEF;
    tick();
    bus.m_resp_valid = 1'b0;
    bus.m_resp_rdata = 32'h0;
    bus.resp_ready   = 4'b0010;
    #1;
    checks++; if ({bus.resp_valid, bus.resp_rdata} !== {4'b0010, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL single_return: got rv=%b d=%h want 0010/deadbeef", bus.resp_valid,
               bus.resp_rdata); end
    checks++; if ({bus.cur_grant, bus.m_resp_ready} !== {2'd1, 1'b0}) begin errors++;
      $display("FAIL single_return_grant: got g=%0d mr=%b want 1/0", bus.cur_grant,
               bus.m_resp_ready); end
    tick();
    #1;
    checks++; if ({bus.busy, bus.resp_valid} !== 5'b0) begin errors++;
      $display("FAIL single_idle: got busy=%b rv=%b want 0/0000", bus.busy, bus.resp_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.resp_ready  = 4'b1111;
    bus.m_req_ready = 1'b1;
    bus.req_valid   = 4'b0101;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++;
      $display("FAIL simul_first: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0100;
    tick();
    bus.m_resp_valid = 1'b1;
    bus.m_resp_rdata = 32'hA0A0_A0A0;
    tick();
    bus.m_resp_valid = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 4'b0001) begin errors++;
      $display("FAIL simul_resp0: got %b want 0001", bus.resp_valid); end
    tick();
    #1;
    checks++; if ({bus.req_ready, bus.busy} !== {4'b0100, 1'b0}) begin errors++;
      $display("FAIL simul_second: got rr=%b busy=%b want 0100/0", bus.req_ready, bus.busy); end
    tick();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.cur_grant !== 2'd2) begin errors++;
      $display("FAIL simul_grant2: got %0d want 2", bus.cur_grant); end
    tick();
    bus.m_resp_valid = 1'b1;
    bus.m_resp_rdata = 32'hB0B0_B0B0;
    tick();
    bus.m_resp_valid = 1'b0;
    #1;
    checks++; if ({bus.resp_valid, bus.resp_rdata} !== {4'b0100, 32'hB0B0_B0B0}) begin
      errors++;
      $display("FAIL simul_resp2: got rv=%b d=%h want 0100/b0b0b0b0", bus.resp_valid,
               bus.resp_rdata); end
    tick();
    // rr_ptr is now 3, so with everyone requesting requester 3 wins.
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++;
      $display("FAIL simul_rrptr3: got %b want 1000", bus.req_ready); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_oh;
    do_reset();
    bus.resp_ready  = 4'b1111;
    bus.m_req_ready = 1'b1;
    bus.req_valid   = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_oh = '0;
      exp_oh[k%4] = 1'b1;
      #1;
      checks++; if ({bus.req_ready, bus.busy} !== {exp_oh, 1'b0}) begin errors++;
        $display("FAIL fair_grant_%0d: got rr=%b busy=%b want %b/0", k, bus.req_ready,
                 bus.busy, exp_oh); end
      tick();
      #1;
      checks++; if (bus.busy !== 1'b1) begin errors++;
        $display("FAIL fair_busy_%0d: got %b want 1", k, bus.busy); end
      tick();
      bus.m_resp_valid = 1'b1;
      bus.m_resp_rdata = 32'(k);
      tick();
      bus.m_resp_valid = 1'b0;
      #1;
      checks++; if ({bus.resp_valid, bus.resp_rdata} !== {exp_oh, 32'(k)}) begin errors++;
        $display("FAIL fair_resp_%0d: got rv=%b d=%h want %b/%h", k, bus.resp_valid,
                 bus.resp_rdata, exp_oh, 32'(k)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.resp_ready  = 4'b1111;
    set_req(0, 1'b1, 32'h40, 32'h1234_5678, 4'b0011);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++;
      $display("FAIL bp_accept: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    // Requester fields change after the accept; the issued request must not follow them.
    set_req(0, 1'b0, 32'hFFFF_FFC0, 32'hA5A5_A5A5, 4'b1100);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.m_req_ready = 1'b1;
      #1;
      checks++; if ({bus.m_req_valid, bus.m_req_is_write, bus.m_req_addr, bus.m_req_wdata,
                     bus.m_req_wstrb, bus.m_resp_ready}
                    !== {2'b11, 32'h40, 32'h1234_5678, 4'b0011, 1'b0}) begin errors++;
        $display("FAIL bp_stall_%0d: got v=%b w=%b a=%h d=%h s=%b want 1/1/40/12345678/0011",
                 i, bus.m_req_valid, bus.m_req_is_write, bus.m_req_addr, bus.m_req_wdata,
                 bus.m_req_wstrb); end
      if (i < 5) tick();
    end
    tick();
    #1;
    checks++; if ({bus.m_req_valid, bus.m_resp_ready} !== 2'b01) begin errors++;
      $display("FAIL bp_single_hs: got mv=%b mr=%b want 0/1", bus.m_req_valid,
               bus.m_resp_ready); end
    tick();
    #1;
    checks++; if (bus.resp_valid !== 4'b0000) begin errors++;
      $display("FAIL bp_no_early_resp: got %b want 0000", bus.resp_valid); end
    bus.m_resp_valid = 1'b1;
    bus.m_resp_rdata = 32'h0BAD_F00D;
    tick();
    bus.m_resp_valid = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 4'b0001) begin errors++;
      $display("FAIL bp_resp: got %b want 0001", bus.resp_valid); end
    tick();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL bp_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_resp_stall();
    do_reset();
    set_req(3, 1'b0, 32'h300, 32'h0, 4'h0);
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++;
      $display("FAIL stall_accept: got %b want 1000", bus.req_ready); end
    tick();
    bus.req_valid    = '0;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_rdata = 32'h5555_5555;
    #1;
    checks++; if ({bus.m_req_valid, bus.m_resp_ready} !== 2'b10) begin errors++;
      $display("FAIL stall_stray_ready: got mv=%b mr=%b want 1/0", bus.m_req_valid,
               bus.m_resp_ready); end
    tick();
    bus.m_resp_valid = 1'b0;
    #1;
    checks++; if ({bus.m_req_valid, bus.resp_valid} !== {1'b1, 4'b0000}) begin errors++;
      $display("FAIL stall_stray_ignored: got mv=%b rv=%b want 1/0000", bus.m_req_valid,
               bus.resp_valid); end
    bus.m_req_ready = 1'b1;
    tick();
    bus.m_req_ready  = 1'b0;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_rdata = 32'hCAFE_F00D;
    tick();
    bus.m_resp_valid = 1'b0;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({bus.resp_valid, bus.resp_rdata, bus.req_ready}
                    !== {4'b1000, 32'hCAFE_F00D, 4'b0000}) begin errors++;
        $display("FAIL stall_hold_%0d: got rv=%b d=%h rr=%b want 1000/cafef00d/0000", i,
                 bus.resp_valid, bus.resp_rdata, bus.req_ready); end
      tick();
    end
    bus.resp_ready = 4'b1000;
    #1;
    checks++; if (bus.resp_valid !== 4'b1000) begin errors++;
      $display("FAIL stall_release: got %b want 1000", bus.resp_valid); end
    tick();
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++;
      $display("FAIL stall_next_grant: got %b want 0001", bus.req_ready); end
  endtask

  task automatic test_reset_wait();
    do_reset();
    bus.resp_ready  = 4'b1111;
    bus.m_req_ready = 1'b1;
    bus.req_valid   = 4'b0100;
    tick();
    bus.req_valid = '0;
    tick();
    bus.m_resp_valid = 1'b1;
    bus.m_resp_rdata = 32'h1;
    tick();
    bus.m_resp_valid = 1'b0;
    tick();
    // rr_ptr is 3 now; requester 1 is reached by wrapping.
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++;
      $display("FAIL rstw_wrap_grant: got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    #1;
    checks++; if (bus.m_resp_ready !== 1'b1) begin errors++;
      $display("FAIL rstw_in_wait: got %b want 1", bus.m_resp_ready); end
    rst_n = 1'b0;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_rdata = 32'h7777_7777;
    #1;
    checks++; if ({bus.busy, bus.m_resp_ready, bus.m_req_valid, bus.resp_valid, bus.req_ready,
                   bus.cur_grant, bus.resp_rdata} !== '0) begin errors++;
      $display("FAIL rstw_outputs: got busy=%b mr=%b rv=%b g=%0d d=%h want all zero",
               bus.busy, bus.m_resp_ready, bus.resp_valid, bus.cur_grant, bus.resp_rdata); end
    tick();
    bus.m_resp_valid = 1'b0;
    rst_n = 1'b1;
    set_req(2, 1'b0, 32'h200, 32'h0, 4'h0);
    bus.req_valid = 4'b1100;
    #1;
    checks++; if ({bus.req_ready, bus.resp_valid} !== {4'b0100, 4'b0000}) begin errors++;
      $display("FAIL rstw_first_grant: got rr=%b rv=%b want 0100/0000", bus.req_ready,
               bus.resp_valid); end
    tick();
    bus.req_valid = 4'b1000;
    #1;
    checks++; if ({bus.m_req_addr, bus.cur_grant} !== {32'h200, 2'd2}) begin errors++;
      $display("FAIL rstw_issue: got a=%h g=%0d want 200/2", bus.m_req_addr, bus.cur_grant); end
    tick();
    bus.m_resp_valid = 1'b1;
    bus.m_resp_rdata = 32'h2222_0000;
    tick();
    bus.m_resp_valid = 1'b0;
    #1;
    checks++; if ({bus.resp_valid, bus.resp_rdata} !== {4'b0100, 32'h2222_0000}) begin
      errors++;
      $display("FAIL rstw_resp: got rv=%b d=%h want 0100/22220000", bus.resp_valid,
               bus.resp_rdata); end
    tick();
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++;
      $display("FAIL rstw_after: got %b want 1000", bus.req_ready); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_resp_stall();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
